// File: rtl/bldc_ctrl_regbank.sv
// BLDC controller host register bank: CTRL/STATUS words and the
// velocity-index to commutation-period lookup. Option: BLDC_LUT_REG_EN.
module bldc_ctrl_regbank #(
  parameter int DATA_W = 32,
  parameter int T_BASE = 5000000
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              write,
  input  logic              read,
  input  logic              addr,
  input  logic [DATA_W-1:0] data_in,
  output logic [DATA_W-1:0] data_out,
  output logic [7:0]        vel,
  output logic [7:0]        duty,
  output logic              en,
  input  logic [2:0]        phase_state,
  output logic [31:0]       T_value
);

  localparam logic ADDR_CTRL = 1'b0;

  localparam logic [31:0] T_1 = 32'(T_BASE / 1);
  localparam logic [31:0] T_2 = 32'(T_BASE / 2);
  localparam logic [31:0] T_3 = 32'(T_BASE / 3);
  localparam logic [31:0] T_4 = 32'(T_BASE / 4);
  localparam logic [31:0] T_5 = 32'(T_BASE / 5);
  localparam logic [31:0] T_6 = 32'(T_BASE / 6);
  localparam logic [31:0] T_7 = 32'(T_BASE / 7);

  typedef struct packed {
    logic [7:0] vel;
    logic [7:0] duty;
    logic       en;
  } ctrl_t;

  ctrl_t       ctrl_q;
  logic [31:0] ctrl_word;
  logic [31:0] stat_word;
  logic [31:0] rd_word;
  logic [31:0] t_lut;
  logic [2:0]  idx;

  assign vel  = ctrl_q.vel;
  assign duty = ctrl_q.duty;
  assign en   = ctrl_q.en;
  assign idx  = ctrl_q.vel[2:0];

  assign ctrl_word = {ctrl_q.vel, ctrl_q.duty,
                      ctrl_q.en, 15'd0};

  assign stat_word = {ctrl_q.vel, ctrl_q.duty,
                      ctrl_q.en, 8'd0, idx,
                      1'b0, phase_state};

  assign rd_word = (addr == ADDR_CTRL) ? ctrl_word
                                       : stat_word;

  // Index 0 means stopped, so it maps to a zero period.
  always_comb begin
    t_lut = '0;
    unique case (idx)
      3'd1:    t_lut = T_1;
      3'd2:    t_lut = T_2;
      3'd3:    t_lut = T_3;
      3'd4:    t_lut = T_4;
      3'd5:    t_lut = T_5;
      3'd6:    t_lut = T_6;
      3'd7:    t_lut = T_7;
      default: t_lut = '0;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ctrl_q <= '0;
    end else if (write && addr == ADDR_CTRL) begin
      ctrl_q.vel  <= data_in[31:24];
      ctrl_q.duty <= data_in[23:16];
      ctrl_q.en   <= data_in[15];
    end
  end

  // Read samples the pre-write CTRL on a combined write+read.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      data_out <= '0;
    end else if (read) begin
      data_out <= rd_word;
    end
  end

`ifdef BLDC_LUT_REG_EN
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      T_value <= '0;
    end else begin
      T_value <= t_lut;
    end
  end
`else
  assign T_value = t_lut;
`endif

endmodule

// File: tb/tb_bldc_ctrl_regbank.sv
// Directed self-checking bench for bldc_ctrl_regbank.
// Vectors and expected words are hand-computed from the register map.
module tb_bldc_ctrl_regbank;

  logic        clk = 1'b0;
  logic        rst;
  logic        write;
  logic        read;
  logic        addr;
  logic [31:0] data_in;
  logic [31:0] data_out;
  logic [7:0]  vel;
  logic [7:0]  duty;
  logic        en;
  logic [2:0]  phase_state;
  logic [31:0] T_value;

  int n_chk = 0;
  int n_err = 0;

  logic [31:0] t_tab [8];
  logic [31:0] hold;

  bldc_ctrl_regbank dut (
    .clk         (clk),
    .rst         (rst),
    .write       (write),
    .read        (read),
    .addr        (addr),
    .data_in     (data_in),
    .data_out    (data_out),
    .vel         (vel),
    .duty        (duty),
    .en          (en),
    .phase_state (phase_state),
    .T_value     (T_value)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h expected 0x%08h",
               tag, got, exp);
    end
  endtask

  task automatic xact(input logic w, input logic r,
                      input logic a, input logic [31:0] d,
                      input logic [2:0] ph);
    @(negedge clk);
    write       = w;
    read        = r;
    addr        = a;
    data_in     = d;
    phase_state = ph;
    @(posedge clk);
    #1;
    write = 1'b0;
    read  = 1'b0;
`ifdef BLDC_LUT_REG_EN
    @(posedge clk);
    #1;
`endif
  endtask

  initial begin
    t_tab[0] = 32'd0;
    t_tab[1] = 32'd5000000;
    t_tab[2] = 32'd2500000;
    t_tab[3] = 32'd1666666;
    t_tab[4] = 32'd1250000;
    t_tab[5] = 32'd1000000;
    t_tab[6] = 32'd833333;
    t_tab[7] = 32'd714285;

    rst = 1'b0;
    write = 1'b0;
    read = 1'b0;
    addr = 1'b0;
    data_in = '0;
    phase_state = '0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_vel", {24'd0, vel}, 32'd0);
    check("rst_duty", {24'd0, duty}, 32'd0);
    check("rst_en", {31'd0, en}, 32'd0);
    check("rst_dout", data_out, 32'd0);
    check("rst_T", T_value, 32'd0);
    rst = 1'b1;
    @(posedge clk);
    #1;
    check("rel_dout", data_out, 32'd0);

    xact(1, 0, 0, 32'h03008000, 3'd0);
    check("w1_vel", {24'd0, vel}, 32'd3);
    check("w1_duty", {24'd0, duty}, 32'd0);
    check("w1_en", {31'd0, en}, 32'd1);
    check("w1_T", T_value, 32'd1666666);
    xact(0, 1, 1, 32'd0, 3'b011);
    check("w1_stat", data_out, 32'h03008033);

    // Read data holds while read is low.
    hold = data_out;
    repeat (3) @(posedge clk);
    #1;
    check("hold", data_out, hold);

    for (int i = 0; i < 4; i++) begin
      logic [7:0] d;
      d = 8'(i * 64);
      xact(1, 0, 0, {8'd3, d, 1'b1, 15'd0}, 3'd0);
      xact(0, 1, 1, 32'd0, 3'd3);
      check("duty_fld", {24'd0, data_out[23:16]}, {24'd0, d});
      check("duty_T", T_value, 32'd1666666);
    end

    for (int v = 0; v < 8; v++) begin
      logic [7:0] vv;
      vv = 8'(v);
      xact(1, 0, 0, {vv, 8'h80, 1'b1, 15'd0}, 3'd0);
      check("vel_T", T_value, t_tab[v]);
      xact(0, 1, 1, 32'd0, vv[2:0]);
      check("vel_stat", data_out,
            {vv, 8'h80, 1'b1, 8'd0, vv[2:0], 1'b0, vv[2:0]});
    end

    xact(1, 0, 1, 32'hFFFFFFFF, 3'd0);
    check("ro_vel", {24'd0, vel}, 32'd7);
    check("ro_duty", {24'd0, duty}, 32'h80);
    xact(0, 1, 0, 32'd0, 3'd0);
    check("ro_ctrl", data_out, 32'h07808000);

    xact(1, 0, 0, 32'h03007FFF, 3'd0);
    xact(0, 1, 0, 32'd0, 3'd0);
    check("lo_bits", data_out, 32'h03000000);

    xact(1, 0, 0, 32'h03008000, 3'd0);
    xact(1, 1, 0, 32'h07FF8000, 3'd0);
    check("wr_dout", data_out, 32'h03008000);
    check("wr_vel", {24'd0, vel}, 32'd7);
    check("wr_duty", {24'd0, duty}, 32'hFF);
    check("wr_T", T_value, 32'd714285);

    xact(1, 0, 0, 32'h0B000000, 3'd0);
    check("wrap_vel", {24'd0, vel}, 32'h0B);
    check("wrap_T", T_value, 32'd1666666);
    check("wrap_en", {31'd0, en}, 32'd0);

    xact(0, 1, 1, 32'd0, 3'd5);
    check("wrap_stat", data_out, 32'h0B000035);

    // Asynchronous reset mid-cycle clears everything at once.
    @(negedge clk);
    #2;
    rst = 1'b0;
    #1;
    check("arst_vel", {24'd0, vel}, 32'd0);
    check("arst_dout", data_out, 32'd0);
    check("arst_T", T_value, 32'd0);
    rst = 1'b1;

    $display("Simulation finished: %0d checks, %0d errors",
             n_chk, n_err);
    $finish;
  end

endmodule

// File: doc/bldc_ctrl_regbank.md
Name:
bldc_ctrl_regbank

Overview:
- Host-accessible register bank for the BLDC motor controller, combined with a velocity-to-commutation-period lookup.
- The host writes one control word (velocity, PWM duty, enable) and reads back control/status.
- The decoded fields drive the PWM generator and the commutation FSM.
- The lookup converts velocity index vel[2:0] into a 32-bit commutation period T (clock cycles) for the commutation timer.

Parameters:
- DATA_W, 32, bus data width (fixed layout below assumes 32).
- T_BASE, 5000000, period numerator. T for index k (k=1..7) is floor(T_BASE/k) cycles; at 50 MHz clock, 100 ms for k=1.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous reset, active-low (asserted when 0).
- write  in  1  write strobe, sampled at rising clk.
- read  in  1  read strobe, sampled at rising clk.
- addr  in  1  register select: 0=CTRL, 1=STATUS.
- data_in  in  32  write data.
- data_out  out  32  registered read data.
- vel  out  8  CTRL[31:24].
- duty  out  8  CTRL[23:16].
- en  out  1  CTRL[15].
- phase_state  in  3  current commutation state from FSM.
- T_value  out  32  commutation period for vel[2:0].

Behaviour:
- Reset (rst=0, async): CTRL=0, data_out=0, vel=0, duty=0, en=0. T_value = LUT(0) = 0.
- CTRL register (addr 0, R/W):
  - [31:24] vel, [23:16] duty, [15] en; bits [14:0] are not stored and read as 0.
  - On a rising edge with write=1 and addr=0, CTRL takes data_in fields.
  - vel/duty/en reflect the new value in the same cycle after the edge (1-cycle write latency).
- STATUS (addr 1, read-only):
  - [31:24] vel, [23:16] duty, [15] en.
  - [14:7]=0, [6:4] = vel[2:0] (active LUT index), [3]=0, [2:0] = phase_state.
  - A write to addr 1 is ignored with no side effect.
- Read:
  - On a rising edge with read=1, data_out is loaded with the addressed word.
  - phase_state is sampled on that edge.
  - data_out holds its value while read=0.
- Simultaneous write=1 and read=1 at addr 0: data_out returns the pre-write CTRL value; CTRL is updated normally.
- LUT, combinational from vel[2:0]; vel[7:3] are ignored, so index wraps modulo 8:
  - 0 -> 0 (motor stopped)
  - 1 -> 5000000
  - 2 -> 2500000
  - 3 -> 1666666
  - 4 -> 1250000
  - 5 -> 1000000
  - 6 -> 833333
  - 7 -> 714285
- Integer division truncates; values are elaboration-time constants derived from T_BASE.
- duty is passed through unmodified. en gating is the PWM block's responsibility.
- Reset asserted mid-operation: all state clears immediately; any pending strobe is lost.

Optional Feature:
- Macro BLDC_LUT_REG_EN.
- Defined: T_value is registered. It updates on the rising edge after vel changes (1-cycle extra latency) and resets to 0.
- Undefined: T_value is purely combinational from vel[2:0].

Test Plan:
- Reset, then release -> vel=0, duty=0, en=0, data_out=0, T_value=0.
- Write addr0 data 0x03008000, then read addr1 with phase_state=3'b011 -> vel=3, duty=0, en=1, T_value=1666666, data_out=0x03008033.
- Sweep duty 0,64,128,192 at vel=3, en=1, each followed by a read of addr1 -> data_out[23:16] = 0x00/0x40/0x80/0xC0, T_value constant 1666666.
- Sweep vel 0..7 with duty=128, en=1 -> T_value follows the table above; data_out[31:24]=v, [6:4]=v.
- Write addr1 with 0xFFFFFFFF -> CTRL unchanged; read addr0 returns the prior CTRL word with [14:0]=0.
- Simultaneous write+read addr0 with 0x07FF8000 over old 0x03008000 -> data_out=0x03008000, then vel=7, T_value=714285. Write vel=0x0B -> T_value=1666666 (index wrap).
